// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 board front end.
package lc3_pkg;

  typedef enum logic [1:0] {S_IDLE, S_PCHK, S_HELD, S_RCHK} btn_state_t;

  // 10 ms of stability at a 50 MHz system clock.
  localparam int DEBOUNCE_50MHZ_10MS = 500000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM, registered level and edge pulses.
module btn_debounce_ch
  import lc3_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             raw;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Synchronizer resets to "released" so a key held through reset must debounce again.
  assign raw = ~sync_q[1];

  // NOTE: every register here is updated with <= so all of them see the pre-edge
  // values of state, cnt and raw; blocking assignments would chain them within a cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q        <= 2'b11;
      state         <= S_IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], key_n};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (raw) begin
            state <= S_PCHK;
            cnt   <= '0;
          end
        end
        S_PCHK: begin
          if (!raw) begin
            state <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= S_HELD;
            level       <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!raw) begin
            state <= S_RCHK;
            cnt   <= '0;
          end
        end
        S_RCHK: begin
          // A bounce back to pressed returns to S_HELD silently; level never dropped.
          if (raw) begin
            state <= S_HELD;
          end else if (cnt == CNT_LAST) begin
            state         <= S_IDLE;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Debounces the active-low board pushbuttons feeding the control unit's Run/Continue inputs.
module btn_conditioner
  import lc3_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_10MS
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] KEY_N,
  output logic [N_BTN-1:0] Level,
  output logic [N_BTN-1:0] Press,
  output logic [N_BTN-1:0] Release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .Clk          (Clk),
      .Reset        (Reset),
      .key_n        (KEY_N[i]),
      .level        (Level[i]),
      .press_pulse  (Press[i]),
      .release_pulse(Release[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench: run-length reference model compared every cycle, plus directed literal checks.
module tb_btn_conditioner;

  localparam int N_BTN = 2;
  localparam int DEB   = 4;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic [N_BTN-1:0] KEY_N = '1;
  logic [N_BTN-1:0] Level, Press, Release;

  int checks = 0;
  int failures = 0;

  btn_conditioner #(
    .N_BTN(N_BTN),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .KEY_N  (KEY_N),
    .Level  (Level),
    .Press  (Press),
    .Release(Release)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the pressed state seen by the debouncer is the raw key delayed by
  // two clocks. The clean level flips once the delayed input has disagreed with it for
  // DEB+1 consecutive clock samples; any agreeing sample restarts the run.
  logic [N_BTN-1:0] m_d1, m_d2, m_level, m_press, m_rel;
  int               m_run [N_BTN];

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_d1    = '1;
      m_d2    = '1;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < N_BTN; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < N_BTN; c++) begin
        logic pressed;
        pressed    = !m_d2[c];
        m_d2[c]    = m_d1[c];
        m_d1[c]    = KEY_N[c];
        m_press[c] = 1'b0;
        m_rel[c]   = 1'b0;
        m_run[c]   = (pressed != m_level[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == DEB + 1) begin
          m_level[c] = ~m_level[c];
          m_run[c]   = 0;
          if (m_level[c]) m_press[c] = 1'b1;
          else            m_rel[c]   = 1'b1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    check("model_level",   32'(Level),   32'(m_level));
    check("model_press",   32'(Press),   32'(m_press));
    check("model_release", 32'(Release), 32'(m_rel));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  int press_cnt;

  initial begin
    // Reset state
    edges(3);
    check("reset_level",   32'(Level),   32'h0);
    check("reset_press",   32'(Press),   32'h0);
    check("reset_release", 32'(Release), 32'h0);
    Reset = 1'b0;

    // Clean press on channel 0: Level and Press after edge 7
    KEY_N = 2'b10;
    edges(6);
    check("press_lat_e6_level", 32'(Level[0]), 32'h0);
    edges(1);
    check("press_lat_e7_level", 32'(Level[0]), 32'h1);
    check("press_lat_e7_press", 32'(Press[0]), 32'h1);
    edges(1);
    check("press_lat_e8_press", 32'(Press[0]), 32'h0);
    check("press_lat_e8_level", 32'(Level[0]), 32'h1);

    // Release bounce while held is rejected
    KEY_N[0] = 1'b1;
    edges(2);
    KEY_N[0] = 1'b0;
    edges(10);
    check("bounce_level_held", 32'(Level[0]), 32'h1);

    // Clean release: Release after 7 edges
    KEY_N[0] = 1'b1;
    edges(6);
    check("rel_lat_e6_level", 32'(Level[0]), 32'h1);
    check("rel_lat_e6_rel",   32'(Release[0]), 32'h0);
    edges(1);
    check("rel_lat_e7_level", 32'(Level[0]), 32'h0);
    check("rel_lat_e7_rel",   32'(Release[0]), 32'h1);
    edges(1);
    check("rel_lat_e8_rel",   32'(Release[0]), 32'h0);

    // Short 3-cycle press is a glitch
    KEY_N[0] = 1'b0;
    edges(3);
    KEY_N[0] = 1'b1;
    edges(10);
    check("glitch_level", 32'(Level[0]), 32'h0);

    // Simultaneous presses, then a glitch on channel 1 only
    KEY_N = 2'b00;
    edges(7);
    check("simul_press", 32'(Press), 32'h3);
    edges(3);
    KEY_N[1] = 1'b1;
    edges(2);
    KEY_N[1] = 1'b0;
    edges(10);
    check("simul_level_after_glitch", 32'(Level), 32'h3);

    // Async reset mid-S_HELD clears Level with no clock edge
    KEY_N = 2'b10;
    Reset = 1'b1;
    #1;
    check("async_reset_level", 32'(Level[0]), 32'h0);
    edges(3);
    Reset = 1'b0;

    // Key held through reset gets a fresh single Press after 7 edges
    edges(6);
    check("post_reset_e6_press", 32'(Press[0]), 32'h0);
    edges(1);
    check("post_reset_e7_press", 32'(Press[0]), 32'h1);
    press_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      edges(1);
      if (Press[0]) press_cnt++;
    end
    check("post_reset_single_press", 32'(press_cnt), 32'h0);
    KEY_N = 2'b11;
    edges(12);

    // Randomised bouncing with occasional reset pulses
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < N_BTN; c++)
        if ($urandom_range(7) == 0) KEY_N[c] = ~KEY_N[c];
      if ($urandom_range(499) == 0) begin
        Reset = 1'b1;
        edges($urandom_range(3, 1));
        Reset = 1'b0;
      end
      edges(1);
    end
    KEY_N = 2'b11;
    edges(12);
    check("final_level_released", 32'(Level), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
